// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider and the HI/LO controller
// that drives it: default width, FSM encoding and the divide-by-zero quotient.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Iteration counter width; must hold DEFAULT_WIDTH-1.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  // Quotient reported when the divisor is zero.
  localparam logic [DEFAULT_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/seq_divider_sub_step.sv
// One restoring-division trial: subtract the divisor magnitude from the
// shifted partial remainder and flag whether the result stayed non-negative.
module div_sub_step
  import seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH + 1
) (
  input  logic [N-1:0] minuend,
  input  logic [N-1:0] subtrahend,
  output logic [N-1:0] diff,
  output logic         non_neg
);

  // Operands never exceed the N-bit signed range, so the MSB is the sign.
  assign diff    = minuend - subtrahend;
  assign non_neg = ~diff[N-1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU. One accepted start produces a
// done_o pulse exactly 34 cycles later, regardless of operands.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Operands as captured with the accepted start.
  logic [WIDTH-1:0] dvd_raw;
  logic [WIDTH-1:0] dsr_raw;
  logic             is_signed;

  // Iteration state: magnitudes, partial remainder R and quotient Q.
  logic [WIDTH-1:0] dsr_mag;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   rem_q;
  logic             sign_q;
  logic             sign_r;
  logic             dz;

  logic             dvd_neg;
  logic             dsr_neg;
  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_b;
  logic [WIDTH:0]   trial_diff;
  logic             trial_ok;

  // Sign of each operand only matters for DIV.
  assign dvd_neg = is_signed & dvd_raw[WIDTH-1];
  assign dsr_neg = is_signed & dsr_raw[WIDTH-1];

  // {R,Q} shifted left by one: the top quotient bit moves into R.
  assign trial_a = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
  assign trial_b = {1'b0, dsr_mag};

  div_sub_step #(
    .N (WIDTH + 1)
  ) u_step (
    .minuend    (trial_a),
    .subtrahend (trial_b),
    .diff       (trial_diff),
    .non_neg    (trial_ok)
  );

  // Controller FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: every register, datapath included, is cleared so an abandoned
      // division leaves no stale sign or magnitude behind.
      state       <= IDLE;
      cnt         <= '0;
      dvd_raw     <= '0;
      dsr_raw     <= '0;
      is_signed   <= 1'b0;
      dsr_mag     <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the register values from before this edge.
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            dvd_raw   <= dividend_i;
            dsr_raw   <= divisor_i;
            is_signed <= signed_i;
            state     <= LOAD;
          end
        end

        LOAD: begin
          // 0x80000000 negates to itself, which reads correctly as 2^31.
          dsr_mag <= dsr_neg ? -dsr_raw : dsr_raw;
          quo_q   <= dvd_neg ? -dvd_raw : dvd_raw;
          rem_q   <= '0;
          sign_q  <= dvd_neg ^ dsr_neg;
          sign_r  <= dvd_neg;
          dz      <= (dsr_raw == '0);
          cnt     <= CNT_W'(WIDTH - 1);
          busy_o  <= 1'b1;
          state   <= RUN;
        end

        RUN: begin
          quo_q <= {quo_q[WIDTH-2:0], trial_ok};
          rem_q <= trial_ok ? trial_diff : trial_a;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        FIX: begin
          if (dz) begin
            quotient_o  <= WIDTH'(DIV_ZERO_QUOT);
            remainder_o <= dvd_raw;
            div_zero_o  <= 1'b1;
          end else begin
            quotient_o  <= sign_q ? -quo_q : quo_q;
            remainder_o <= sign_r ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            div_zero_o  <= 1'b0;
          end
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues the expected result and
// completion cycle of each accepted start; a monitor checks busy_o every
// cycle and pops/compares the queue head whenever done_o is seen.
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          done_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_in;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_edge = -1;
  exp_t sb[$];

  seq_divider #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .signed_i    (signed_in),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .busy_o      (busy),
    .done_o      (done),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .div_zero_o  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a falling edge; start is sampled by the next rising edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz);
    exp_t e;
    dividend  = a;
    divisor   = b;
    signed_in = s;
    start     = 1'b1;
    acc_edge  = cyc + 1;
    e.q = eq; e.r = er; e.dz = edz; e.done_cyc = cyc + 1 + 34;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the falling edge inside the done_o cycle.
  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Monitor: busy window every cycle, results and timing on each done_o.
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_busy;
      exp_busy = (acc_edge >= 0) && (cyc > acc_edge) && (cyc <= acc_edge + 33);
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("quotient",   quotient, e.q);
          check("remainder",  remainder, e.r);
          check("div_zero",   {31'd0, div_zero}, {31'd0, e.dz});
        end
      end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        check("done_missing", {31'd0, done}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; signed_in = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_done",      {31'd0, done}, 32'd0);
    check("rst_quotient",  quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_div_zero",  {31'd0, div_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic unsigned and signed cases; each start lands in the previous done cycle.
    issue(32'd100,       32'd7,          1'b0, 32'd14,        32'd2,          1'b0); wait_done();
    issue(32'hFFFFFF9C,  32'd7,          1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE,   1'b0); wait_done();
    issue(32'd100,       32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,  32'd2,          1'b0); wait_done();
    issue(32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000,  32'd0,          1'b0); wait_done();
    issue(32'h80000000,  32'hFFFFFFFF,   1'b0, 32'd0,         32'h80000000,   1'b0); wait_done();
    issue(32'hFFFFFFFF,  32'd1,          1'b0, 32'hFFFFFFFF,  32'd0,          1'b0); wait_done();

    // Divide by zero in both modes.
    issue(32'd5,         32'd0,          1'b0, 32'hFFFFFFFF,  32'd5,          1'b1); wait_done();
    issue(32'd5,         32'd0,          1'b1, 32'hFFFFFFFF,  32'd5,          1'b1); wait_done();
    issue(32'hFFFFFFFB,  32'd0,          1'b1, 32'hFFFFFFFF,  32'hFFFFFFFB,   1'b1); wait_done();

    // A second start while busy must be ignored.
    issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);
    while (cyc < acc_edge + 9) @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; signed_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Previous results stay visible while the next division runs.
    issue(32'h12345678, 32'h100, 1'b0, 32'h00123456, 32'h78, 1'b0); wait_done();
    issue(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14, 32'hFFFFFFFE, 1'b0);
    repeat (5) @(negedge clk);
    check("held_quotient",  quotient, 32'h00123456);
    check("held_remainder", remainder, 32'h78);
    wait_done();

    // Asynchronous reset mid-division clears outputs at once; no done follows.
    issue(32'd999, 32'd10, 1'b0, 32'd99, 32'd9, 1'b0);
    while (cyc < acc_edge + 20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",      {31'd0, busy}, 32'd0);
    check("midrst_done",      {31'd0, done}, 32'd0);
    check("midrst_quotient",  quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_div_zero",  {31'd0, div_zero}, 32'd0);
    sb.delete();
    acc_edge = -1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue(32'd77, 32'd8, 1'b0, 32'd9, 32'd5, 1'b0); wait_done();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
